alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: one-hot-opcode ALU with a valid/ready request side and a
// valid/ready result side. NOT/OR/AND/ADD/SUB/XOR finish in one cycle; MUL
// is an unsigned shift-add taking WIDTH cycles. Illegal opcodes return an
// error result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   opFlag[6:0]         one-hot op: NOT,OR,AND,ADD,SUB,XOR,MUL (bit0..6)
//   a1, a2, cin         operands and carry/borrow in
//   out_valid/out_ready result handshake
//   out, out_hi         result low/high half (out_hi nonzero only for MUL)
//   cout, zero, err     carry/borrow, {out_hi,out}==0, illegal opcode
module alu_multicycle #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opFlag,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] a2,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             cout,
   output logic             zero,
   output logic             err
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   out_q;
   logic [WIDTH-1:0]   hi_q;
   logic               cout_q;
   logic               zero_q;
   logic               err_q;
   logic               valid_q;

   // Shift-add multiplier datapath
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [CW-1:0]      cnt_q;

   // Single-cycle result decode
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     dif_w;
   logic [WIDTH-1:0]   res_lo;
   logic               res_c;
   logic               illegal;
   logic               is_mul;

   assign sum_w = {1'b0, a1} + {1'b0, a2} + {{WIDTH{1'b0}}, cin};
   // Bit WIDTH of the extended difference is the borrow out.
   assign dif_w = {1'b0, a1} - {1'b0, a2} - {{WIDTH{1'b0}}, cin};

   always_comb begin
      res_lo  = '0;
      res_c   = 1'b0;
      illegal = 1'b0;
      is_mul  = 1'b0;
      case (opFlag)
         7'b0000001: res_lo = ~a1;
         7'b0000010: res_lo = a1 | a2;
         7'b0000100: res_lo = a1 & a2;
         7'b0001000: begin
            res_lo = sum_w[WIDTH-1:0];
            res_c  = sum_w[WIDTH];
         end
         7'b0010000: begin
            res_lo = dif_w[WIDTH-1:0];
            res_c  = dif_w[WIDTH];
         end
         7'b0100000: res_lo = a1 ^ a2;
         7'b1000000: begin
            if (MUL_EN != 0) is_mul  = 1'b1;
            else             illegal = 1'b1;
         end
         default:    illegal = 1'b1;
      endcase
   end

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         out_q    <= '0;
         hi_q     <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b1;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (illegal) begin
                     out_q   <= '0;
                     hi_q    <= '0;
                     cout_q  <= 1'b0;
                     zero_q  <= 1'b1;
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else if (is_mul) begin
                     mcand_q  <= {{WIDTH{1'b0}}, a1};
                     mplier_q <= a2;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= EXEC;
                  end else begin
                     out_q   <= res_lo;
                     hi_q    <= '0;
                     cout_q  <= res_c;
                     zero_q  <= (res_lo == '0);
                     err_q   <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            EXEC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               // Last multiplier bit: publish the finished product.
               if (cnt_q == LAST) begin
                  out_q   <= acc_d[WIDTH-1:0];
                  hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                  cout_q  <= 1'b0;
                  zero_q  <= (acc_d == '0);
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = valid_q;
   assign out       = out_q;
   assign out_hi    = hi_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule
